// File: rtl/jump_redirect_ctrl.sv
// Redirect sequencer between EX/trap logic and fetch: latches a jump or trap target,
// offers it on a valid/ready handshake, then flushes IF/ID for FLUSH_CYCLES cycles.
module jump_redirect_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  jump_enable_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_req_i,
    input  logic [ADDR_WIDTH-1:0] trap_addr_i,
    input  logic                  fetch_ready_i,
    output logic                  redirect_valid_o,
    output logic [ADDR_WIDTH-1:0] redirect_addr_o,
    output logic                  hold_o,
    output logic                  flush_o,
    output logic                  misalign_o,
    output logic [CNT_WIDTH-1:0]  jump_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic {
        KIND_JUMP = 1'b0,
        KIND_TRAP = 1'b1
    } kind_t;

    localparam logic [3:0]           FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
            $error("jump_redirect_ctrl: FLUSH_CYCLES must be within 1..15");
        end
    endgenerate

    state_t                  state;
    kind_t                   kind;
    logic [ADDR_WIDTH-1:0]   target_q;
    logic [ADDR_WIDTH-1:0]   trap_addr_pend;
    logic                    trap_pend;
    logic [3:0]              flush_cnt;
    logic [CNT_WIDTH-1:0]    jump_cnt;
    logic                    valid_q;
    logic                    hold_q;
    logic                    flush_q;
    logic                    misalign_q;

    logic                    jump_misaligned;

    assign jump_misaligned = (jump_addr_i[1:0] != 2'b00);

    // NOTE: every register here, including the address latches, is reset so that
    // an in-flight redirect is dropped cleanly and the outputs read 0 during reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            kind           <= KIND_JUMP;
            target_q       <= '0;
            trap_addr_pend <= '0;
            trap_pend      <= 1'b0;
            flush_cnt      <= '0;
            jump_cnt       <= '0;
            valid_q        <= 1'b0;
            hold_q         <= 1'b0;
            flush_q        <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only; the default below is overridden
            // by later assignments in the same edge, which NBA ordering guarantees.
            misalign_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (trap_req_i) begin
                        target_q <= trap_addr_i;
                        kind     <= KIND_TRAP;
                        state    <= REQ;
                        valid_q  <= 1'b1;
                        hold_q   <= 1'b1;
                        flush_q  <= 1'b1;
                    end else if (jump_enable_i && jump_misaligned) begin
                        misalign_q <= 1'b1;
                    end else if (jump_enable_i) begin
                        target_q <= jump_addr_i;
                        kind     <= KIND_JUMP;
                        state    <= REQ;
                        valid_q  <= 1'b1;
                        hold_q   <= 1'b1;
                        flush_q  <= 1'b1;
                    end
                end

                REQ: begin
                    // A trap never displaces the offered target; it waits its turn.
                    if (trap_req_i) begin
                        trap_pend      <= 1'b1;
                        trap_addr_pend <= trap_addr_i;
                    end
                    if (fetch_ready_i) begin
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                        valid_q   <= 1'b0;
                        hold_q    <= 1'b0;
                        flush_q   <= 1'b1;
                        if (kind == KIND_JUMP && jump_cnt != CNT_MAX) begin
                            jump_cnt <= jump_cnt + 1'b1;
                        end
                    end
                end

                FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        flush_cnt <= '0;
                        if (trap_req_i) begin
                            // A trap arriving on the last flush cycle is the newest one.
                            target_q  <= trap_addr_i;
                            kind      <= KIND_TRAP;
                            trap_pend <= 1'b0;
                            state     <= REQ;
                            valid_q   <= 1'b1;
                            hold_q    <= 1'b1;
                            flush_q   <= 1'b1;
                        end else if (trap_pend) begin
                            target_q  <= trap_addr_pend;
                            kind      <= KIND_TRAP;
                            trap_pend <= 1'b0;
                            state     <= REQ;
                            valid_q   <= 1'b1;
                            hold_q    <= 1'b1;
                            flush_q   <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            flush_q <= 1'b0;
                        end
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                        if (trap_req_i) begin
                            trap_pend      <= 1'b1;
                            trap_addr_pend <= trap_addr_i;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    hold_q  <= 1'b0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid_o = valid_q;
    assign redirect_addr_o  = target_q;
    assign hold_o           = hold_q;
    assign flush_o          = flush_q;
    assign misalign_o       = misalign_q;
    assign jump_cnt_o       = jump_cnt;

endmodule
